// File: rtl/pwm_pkg.sv
// Shared types and helpers for the PWM receive-side monitor.
// Holds the lock FSM state encoding and the run-length deviation function.
package pwm_pkg;

    localparam int PWM_CNT_W  = 16;
    // Working width for deviation maths; run counters up to this width are supported.
    localparam int PWM_DIFF_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        SEEK,
        ACQ,
        LOCK
    } pwm_mon_state_t;

    // Unsigned |a-b| as max-min, so it can never wrap.
    function automatic logic [PWM_DIFF_W-1:0] abs_diff(
        input logic [PWM_DIFF_W-1:0] a,
        input logic [PWM_DIFF_W-1:0] b
    );
        return (a > b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/pwm_edge_sync.sv
// Brings the asynchronous PWM stream into the clk domain and flags its edges.
// rise/fall are single-cycle pulses aligned with the first cycle of the new level on s.
module pwm_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic in,
    output logic s,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync;
    logic                   s_d;

    // NOTE: non-blocking assignments make every flop sample its pre-edge input, so the
    // chain really is SYNC_STAGES deep; blocking ones would collapse it into one stage.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync <= '0;
            s_d  <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], in};
            s_d  <= sync[SYNC_STAGES-1];
        end
    end

    assign s    = sync[SYNC_STAGES-1];
    assign rise = s & ~s_d;
    assign fall = ~s & s_d;

endmodule

// File: rtl/pwm_mon.sv
// PWM stream checker: measures low/high run lengths, compares each period against the
// expected widths within a tolerance, and tracks lock with a small acquisition FSM.
module pwm_mon
    import pwm_pkg::*;
#(
    parameter int CNT_W       = PWM_CNT_W,
    parameter int SYNC_STAGES = 2,
    parameter int LOCK_CNT    = 4,
    parameter int UNLOCK_CNT  = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             in,
    input  logic [CNT_W-1:0] exp_high,
    input  logic [CNT_W-1:0] exp_low,
    input  logic [CNT_W-1:0] tol,
    output logic             meas_valid,
    output logic [CNT_W-1:0] high_len,
    output logic [CNT_W-1:0] low_len,
    output logic             period_ok,
    output logic             locked,
    output logic             timeout,
    output logic [15:0]      err_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam int GOOD_W = $clog2(LOCK_CNT + 1);
    localparam int BAD_W  = $clog2(UNLOCK_CNT + 1);

    pwm_mon_state_t   state;
    logic [CNT_W-1:0] run_cnt;
    logic [CNT_W-1:0] run_nxt;
    logic [CNT_W-1:0] low_hold;
    logic             low_sat;
    logic             have_low;
    logic [GOOD_W-1:0] good_cnt;
    logic [BAD_W-1:0]  bad_cnt;

    logic s;
    logic rise;
    logic fall;
    logic any_edge;
    logic counting;

    logic [PWM_DIFF_W-1:0] high_dev;
    logic [PWM_DIFF_W-1:0] low_dev;
    logic [PWM_DIFF_W-1:0] tol_w;
    logic                  cur_ok;

    pwm_edge_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk  (clk),
        .rst  (rst),
        .in   (in),
        .s    (s),
        .rise (rise),
        .fall (fall)
    );

    assign any_edge = rise | fall;
    assign counting = (state == ACQ) || (state == LOCK);

    assign run_nxt = any_edge             ? CNT_W'(1) :
                     (run_cnt == CNT_MAX) ? run_cnt   :
                                            run_cnt + 1'b1;

    // Evaluated on the closing (falling) edge: run_cnt still holds the finished high run.
    assign high_dev = abs_diff(PWM_DIFF_W'(run_cnt), PWM_DIFF_W'(exp_high));
    assign low_dev  = abs_diff(PWM_DIFF_W'(low_hold), PWM_DIFF_W'(exp_low));
    assign tol_w    = PWM_DIFF_W'(tol);
    assign cur_ok   = (high_dev <= tol_w) && (low_dev <= tol_w) &&
                      (run_cnt != CNT_MAX) && !low_sat;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            run_cnt    <= '0;
            low_hold   <= '0;
            low_sat    <= 1'b0;
            have_low   <= 1'b0;
            good_cnt   <= '0;
            bad_cnt    <= '0;
            meas_valid <= 1'b0;
            high_len   <= '0;
            low_len    <= '0;
            period_ok  <= 1'b0;
            locked     <= 1'b0;
            timeout    <= 1'b0;
            err_cnt    <= '0;
        end else begin
            meas_valid <= 1'b0;
            if (!en) begin
                state    <= IDLE;
                run_cnt  <= '0;
                low_sat  <= 1'b0;
                have_low <= 1'b0;
                good_cnt <= '0;
                bad_cnt  <= '0;
                locked   <= 1'b0;
                timeout  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        locked <= 1'b0;
                        state  <= SEEK;
                    end
                    SEEK: begin
                        // The run in progress on entry is partial; only start timing here.
                        if (any_edge) begin
                            state    <= ACQ;
                            run_cnt  <= CNT_W'(1);
                            have_low <= 1'b0;
                            low_sat  <= 1'b0;
                            good_cnt <= '0;
                            bad_cnt  <= '0;
                        end
                    end
                    default: begin
                        run_cnt <= run_nxt;
                        if (counting && run_nxt == CNT_MAX)
                            timeout <= 1'b1;

                        if (any_edge && s) begin
                            low_hold <= run_cnt;
                            low_sat  <= (run_cnt == CNT_MAX);
                            have_low <= 1'b1;
                        end

                        if (any_edge && !s && have_low) begin
                            high_len   <= run_cnt;
                            low_len    <= low_hold;
                            period_ok  <= cur_ok;
                            meas_valid <= 1'b1;
                        end

                        // Lock bookkeeping acts on the registered strobe, one cycle later.
                        if (meas_valid) begin
                            if (state == ACQ) begin
                                if (!period_ok) begin
                                    good_cnt <= '0;
                                end else if (good_cnt == GOOD_W'(LOCK_CNT - 1)) begin
                                    state    <= LOCK;
                                    locked   <= 1'b1;
                                    good_cnt <= '0;
                                    bad_cnt  <= '0;
                                end else begin
                                    good_cnt <= good_cnt + 1'b1;
                                end
                            end else begin
                                if (period_ok) begin
                                    bad_cnt <= '0;
                                end else begin
                                    if (err_cnt != 16'hFFFF)
                                        err_cnt <= err_cnt + 16'd1;
                                    if (bad_cnt == BAD_W'(UNLOCK_CNT - 1)) begin
                                        state    <= ACQ;
                                        locked   <= 1'b0;
                                        good_cnt <= '0;
                                        bad_cnt  <= '0;
                                    end else begin
                                        bad_cnt <= bad_cnt + 1'b1;
                                    end
                                end
                            end
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pwm_mon.sv
// Self-checking bench for pwm_mon: a scoreboard of expected periods for a 16-bit
// instance, plus an 8-bit instance used to exercise run-counter saturation.
module tb_pwm_mon;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en  = 1'b0;
    logic        in  = 1'b0;
    logic        in8 = 1'b0;
    logic [15:0] exp_high = 16'd3;
    logic [15:0] exp_low  = 16'd3;
    logic [15:0] tol      = 16'd0;

    logic        meas_valid, period_ok, locked, timeout;
    logic [15:0] high_len, low_len, err_cnt;

    logic        mv8, ok8, locked8, to8;
    logic [7:0]  hl8, ll8;
    logic [15:0] err8;

    always #5 clk = ~clk;

    pwm_mon #(.CNT_W(16), .SYNC_STAGES(2), .LOCK_CNT(4), .UNLOCK_CNT(2)) dut (
        .clk(clk), .rst(rst), .en(en), .in(in),
        .exp_high(exp_high), .exp_low(exp_low), .tol(tol),
        .meas_valid(meas_valid), .high_len(high_len), .low_len(low_len),
        .period_ok(period_ok), .locked(locked), .timeout(timeout), .err_cnt(err_cnt)
    );

    pwm_mon #(.CNT_W(8), .SYNC_STAGES(2), .LOCK_CNT(4), .UNLOCK_CNT(2)) dut8 (
        .clk(clk), .rst(rst), .en(en), .in(in8),
        .exp_high(exp_high[7:0]), .exp_low(exp_low[7:0]), .tol(tol[7:0]),
        .meas_valid(mv8), .high_len(hl8), .low_len(ll8),
        .period_ok(ok8), .locked(locked8), .timeout(to8), .err_cnt(err8)
    );

    typedef struct {
        int h;
        int l;
        bit ok;
    } exp_t;

    exp_t sb[$];
    int   checks  = 0;
    int   errors  = 0;
    int   low_acc = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    function automatic bit model_ok(input int h, input int l, input int maxv);
        int dh, dl;
        dh = (h > int'(exp_high)) ? h - int'(exp_high) : int'(exp_high) - h;
        dl = (l > int'(exp_low))  ? l - int'(exp_low)  : int'(exp_low)  - l;
        return (h != maxv) && (l != maxv) && (dh <= int'(tol)) && (dl <= int'(tol));
    endfunction

    // Drive the main stream; low_acc tracks how long the line has been low already.
    task automatic hold(input logic lvl, input int n);
        in = lvl;
        if (lvl) low_acc = 0;
        else     low_acc += n;
        repeat (n) @(negedge clk);
    endtask

    task automatic period(input int lo, input int hi, input bit push);
        exp_t e;
        if (push) begin
            e.h  = hi;
            e.l  = low_acc + lo;
            e.ok = model_ok(e.h, e.l, 65535);
            sb.push_back(e);
        end
        hold(1'b0, lo);
        hold(1'b1, hi);
    endtask

    task automatic hold8(input logic lvl, input int n);
        in8 = lvl;
        repeat (n) @(negedge clk);
    endtask

    task automatic en_pulse();
        en = 1'b0;
        @(negedge clk);
        en = 1'b1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (meas_valid === 1'b1) begin
            if (sb.size() == 0) begin
                check("mv_unexpected", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("high_len", 32'(high_len), 32'(e.h));
                check("low_len", 32'(low_len), 32'(e.l));
                check("period_ok", 32'(period_ok), 32'(e.ok));
            end
        end
    end

    initial begin
        bit got;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_mv", 32'(meas_valid), 32'd0);
        check("rst_locked", 32'(locked), 32'd0);
        check("rst_timeout", 32'(timeout), 32'd0);
        check("rst_err", 32'(err_cnt), 32'd0);
        check("rst_high", 32'(high_len), 32'd0);
        rst = 1'b1;
        en  = 1'b1;
        hold(1'b0, 4);

        // 3/3 stream, tol 0: lock after four good periods
        period(3, 3, 1'b0);
        repeat (6) period(3, 3, 1'b1);
        check("a_locked", 32'(locked), 32'd1);
        check("a_err", 32'(err_cnt), 32'd0);

        // Two bad 5-high/1-low periods drop lock, then 3/3 re-acquires
        period(1, 5, 1'b1);
        period(1, 5, 1'b1);
        period(3, 3, 1'b1);
        check("b_unlocked", 32'(locked), 32'd0);
        check("b_err", 32'(err_cnt), 32'd2);
        repeat (5) period(3, 3, 1'b1);
        check("b_relocked", 32'(locked), 32'd1);
        check("b_err_hold", 32'(err_cnt), 32'd2);

        // One-cycle enable drop while locked
        hold(1'b0, 6);
        en_pulse();
        check("c_locked", 32'(locked), 32'd0);
        check("c_timeout", 32'(timeout), 32'd0);
        check("c_err", 32'(err_cnt), 32'd2);
        check("c_high", 32'(high_len), 32'd3);
        check("c_low", 32'(low_len), 32'd3);
        period(3, 3, 1'b0);
        repeat (5) period(3, 3, 1'b1);
        check("c_relocked", 32'(locked), 32'd1);

        // 2 high / 4 low against 3/3: passes with tol 1, fails with tol 0
        hold(1'b0, 6);
        tol = 16'd1;
        en_pulse();
        period(4, 2, 1'b0);
        repeat (6) period(4, 2, 1'b1);
        check("d_locked_tol1", 32'(locked), 32'd1);
        hold(1'b0, 6);
        tol = 16'd0;
        en_pulse();
        period(4, 2, 1'b0);
        repeat (6) period(4, 2, 1'b1);
        check("d_locked_tol0", 32'(locked), 32'd0);

        // Asynchronous reset pulse in LOCK
        hold(1'b0, 6);
        en_pulse();
        period(3, 3, 1'b0);
        repeat (6) period(3, 3, 1'b1);
        check("e_locked", 32'(locked), 32'd1);
        hold(1'b0, 6);
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("e_rst_locked", 32'(locked), 32'd0);
        check("e_rst_err", 32'(err_cnt), 32'd0);
        check("e_rst_high", 32'(high_len), 32'd0);
        check("e_rst_low", 32'(low_len), 32'd0);
        check("e_rst_ok", 32'(period_ok), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        hold(1'b0, 3);
        period(3, 3, 1'b0);
        repeat (2) period(3, 3, 1'b1);
        hold(1'b0, 6);
        check("e_mv_count", 32'(sb.size()), 32'd0);

        // 8-bit instance: lock, then stick high until the run counter saturates
        repeat (7) begin
            hold8(1'b0, 3);
            hold8(1'b1, 3);
        end
        check("f_locked8", 32'(locked8), 32'd1);
        hold8(1'b0, 3);
        hold8(1'b1, 200);
        check("f_timeout_early", 32'(to8), 32'd0);
        hold8(1'b1, 70);
        check("f_timeout", 32'(to8), 32'd1);
        in8 = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (mv8) begin
                got = 1'b1;
                break;
            end
        end
        check("f_mv8_seen", 32'(got), 32'd1);
        check("f_high8", 32'(hl8), 32'd255);
        check("f_low8", 32'(ll8), 32'd3);
        check("f_ok8", 32'(ok8), 32'd0);
        repeat (2) @(negedge clk);
        check("f_err8", 32'(err8), 32'd1);
        check("f_main_timeout", 32'(timeout), 32'd0);

        check("sb_drain", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
